// File: rtl/pc_source_select_if.sv
// pc_source_select_if
//   Bundles the fetch-head redirect inputs and the PC outputs of
//   pc_source_select.
//   master : the driver of stall/src_valid/src_addr that consumes pc & flags
//   slave  : the pc_source_select block itself
//   Signals: stall, src_valid[NSRC], src_addr[NSRC*WIDTH] (source k at
//   [k*WIDTH +: WIDTH]), pc, pc_prev, redirect, redirect_src[3], misaligned,
//   pending, and redirect_count[32] when PC_REDIRECT_COUNT_EN is defined.
interface pc_source_select_if #(
   parameter int WIDTH = 32,
   parameter int NSRC  = 4
);
   logic                  stall;
   logic [NSRC-1:0]       src_valid;
   logic [NSRC*WIDTH-1:0] src_addr;
   logic [WIDTH-1:0]      pc;
   logic [WIDTH-1:0]      pc_prev;
   logic                  redirect;
   logic [2:0]            redirect_src;
   logic                  misaligned;
   logic                  pending;
`ifdef PC_REDIRECT_COUNT_EN
   logic [31:0]           redirect_count;

   modport master (
      output stall, src_valid, src_addr,
      input  pc, pc_prev, redirect, redirect_src, misaligned, pending, redirect_count
   );
   modport slave (
      input  stall, src_valid, src_addr,
      output pc, pc_prev, redirect, redirect_src, misaligned, pending, redirect_count
   );
`else
   modport master (
      output stall, src_valid, src_addr,
      input  pc, pc_prev, redirect, redirect_src, misaligned, pending
   );
   modport slave (
      input  stall, src_valid, src_addr,
      output pc, pc_prev, redirect, redirect_src, misaligned, pending
   );
`endif
endinterface

// File: rtl/pc_source_select.sv
// pc_source_select
//   N-way priority next-PC selector with the PC register folded in.
//   Highest source index wins; a redirect arriving during a stall is latched
//   as pending and applied on the first unstalled edge. Targets are forced to
//   4-byte alignment and a misaligned target is flagged for one cycle.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-high reset
//   bus    - pc_source_select_if.slave (stall, sources in; pc & flags out)
// Optional build macro: PC_REDIRECT_COUNT_EN adds a saturating 32-bit
//   redirect_count on the interface.
//
// state    | meaning
// ST_IDLE  | no redirect latched
// ST_PEND  | a redirect arrived under stall and waits for release
module pc_source_select #(
   parameter int          WIDTH        = 32,
   parameter int          NSRC         = 4,
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          INC          = 4
) (
   input logic              clock,
   input logic              reset,
   pc_source_select_if.slave bus
);
   localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VECTOR);

   typedef enum logic {ST_IDLE, ST_PEND} state_t;

   state_t           state, state_nxt;
   logic [2:0]       pend_idx, pend_idx_nxt;
   logic [WIDTH-1:0] pend_addr, pend_addr_nxt;
   logic [WIDTH-1:0] pc_q, pc_nxt, prev_q, prev_nxt;
   logic             redirect_q, redirect_nxt;
   logic [2:0]       src_q, src_nxt;
   logic             mis_q, mis_nxt;

   logic             req_hit, req_wins;
   logic [2:0]       req_idx, tgt_idx;
   logic [WIDTH-1:0] req_addr, tgt_addr;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         pend_idx   <= '0;
         pend_addr  <= '0;
         pc_q       <= RST_PC;
         prev_q     <= RST_PC;
         redirect_q <= 1'b0;
         src_q      <= '0;
         mis_q      <= 1'b0;
      end else begin
         state      <= state_nxt;
         pend_idx   <= pend_idx_nxt;
         pend_addr  <= pend_addr_nxt;
         pc_q       <= pc_nxt;
         prev_q     <= prev_nxt;
         redirect_q <= redirect_nxt;
         src_q      <= src_nxt;
         mis_q      <= mis_nxt;
      end
   end

   always_comb begin
      req_hit  = 1'b0;
      req_idx  = '0;
      req_addr = '0;
      // ascending scan: the last asserted source seen is the highest index
      for (int k = 0; k < NSRC; k++) begin
         if (bus.src_valid[k]) begin
            req_hit  = 1'b1;
            req_idx  = 3'(k);
            req_addr = bus.src_addr[k*WIDTH +: WIDTH];
         end
      end
      // equal index counts as a win so a fresh request replaces a stale one
      req_wins = req_hit && ((state == ST_IDLE) || (req_idx >= pend_idx));
      tgt_idx  = req_wins ? req_idx  : pend_idx;
      tgt_addr = req_wins ? req_addr : pend_addr;

      state_nxt     = state;
      pend_idx_nxt  = pend_idx;
      pend_addr_nxt = pend_addr;
      pc_nxt        = pc_q;
      prev_nxt      = prev_q;
      redirect_nxt  = 1'b0;
      src_nxt       = src_q;
      mis_nxt       = 1'b0;

      if (bus.stall) begin
         if (req_wins) begin
            state_nxt     = ST_PEND;
            pend_idx_nxt  = req_idx;
            pend_addr_nxt = req_addr;
         end
      end else begin
         prev_nxt = pc_q;
         if (req_wins || (state == ST_PEND)) begin
            pc_nxt       = {tgt_addr[WIDTH-1:2], 2'b00};
            redirect_nxt = 1'b1;
            src_nxt      = tgt_idx;
            mis_nxt      = |tgt_addr[1:0];
            state_nxt    = ST_IDLE;
         end else begin
            pc_nxt = pc_q + WIDTH'(INC);
         end
      end
   end

`ifdef PC_REDIRECT_COUNT_EN
   logic [31:0] count_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (redirect_nxt && (count_q != 32'hFFFF_FFFF)) begin
         count_q <= count_q + 32'd1;
      end
   end

   assign bus.redirect_count = count_q;
`endif

   assign bus.pc           = pc_q;
   assign bus.pc_prev      = prev_q;
   assign bus.redirect     = redirect_q;
   assign bus.redirect_src = src_q;
   assign bus.misaligned   = mis_q;
   assign bus.pending      = (state == ST_PEND);
endmodule

// File: tb/tb_pc_source_select.sv
// tb_pc_source_select
//   Scoreboard bench: each stimulus cycle runs a behavioural model and queues
//   the expected post-edge outputs; a monitor pops and compares after every
//   rising edge. Directed scenarios are followed by randomized traffic.
module tb_pc_source_select;
   localparam int WIDTH = 32;
   localparam int NSRC  = 4;

   logic clock;
   logic reset;

   pc_source_select_if #(.WIDTH(WIDTH), .NSRC(NSRC)) bus ();

   pc_source_select #(
      .WIDTH(WIDTH), .NSRC(NSRC), .RESET_VECTOR(32'h0000_0000), .INC(4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] prev;
      logic        redir;
      logic [2:0]  src;
      logic        mis;
      logic        pend;
      logic [31:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // reference model state
   logic [31:0] m_pc, m_prev, m_pa, m_cnt;
   logic        m_redir, m_mis, m_pv;
   logic [2:0]  m_src;
   int          m_pi;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic m_reset();
      m_pc = 0; m_prev = 0; m_redir = 0; m_src = 0; m_mis = 0;
      m_pv = 0; m_pi = 0; m_pa = 0; m_cnt = 0;
   endtask

   function automatic logic [31:0] addr_of(input logic [127:0] a, input int k);
      return a[k*32 +: 32];
   endfunction

   // one clock edge of the specified behaviour
   task automatic m_step(input logic st, input logic [3:0] v, input logic [127:0] a);
      int          best;
      logic [31:0] ba;
      exp_t        e;
      best = -1;
      ba   = 0;
      for (int k = 0; k < NSRC; k++)
         if (v[k]) begin best = k; ba = addr_of(a, k); end
      if (reset) begin
         m_reset();
      end else if (st) begin
         m_redir = 0;
         m_mis   = 0;
         if (best >= 0 && (!m_pv || best >= m_pi)) begin
            m_pv = 1; m_pi = best; m_pa = ba;
         end
      end else begin
         if (m_pv && m_pi > best) begin best = m_pi; ba = m_pa; end
         m_prev = m_pc;
         if (best >= 0) begin
            m_pc    = ba & 32'hFFFF_FFFC;
            m_redir = 1;
            m_src   = 3'(best);
            m_mis   = (ba[1:0] != 2'b00);
            m_pv    = 0;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
         end else begin
            m_pc    = m_pc + 4;
            m_redir = 0;
            m_mis   = 0;
         end
      end
      e.pc = m_pc; e.prev = m_prev; e.redir = m_redir; e.src = m_src;
      e.mis = m_mis; e.pend = m_pv; e.cnt = m_cnt;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic st, input logic [3:0] v, input logic [127:0] a);
      @(negedge clock);
      bus.stall     = st;
      bus.src_valid = v;
      bus.src_addr  = a;
      m_step(st, v, a);
   endtask

   task automatic settle();
      @(posedge clock);
      #2;
   endtask

   function automatic logic [127:0] pk(input logic [31:0] a3, a2, a1, a0);
      return {a3, a2, a1, a0};
   endfunction

   // monitor: outputs are presented every cycle
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_pc",           bus.pc,                  e.pc);
            chk("sb_pc_prev",      bus.pc_prev,             e.prev);
            chk("sb_redirect",     32'(bus.redirect),       32'(e.redir));
            chk("sb_redirect_src", 32'(bus.redirect_src),   32'(e.src));
            chk("sb_misaligned",   32'(bus.misaligned),     32'(e.mis));
            chk("sb_pending",      32'(bus.pending),        32'(e.pend));
`ifdef PC_REDIRECT_COUNT_EN
            chk("sb_count",        bus.redirect_count,      e.cnt);
`endif
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b1;
      bus.stall     = 1'b0;
      bus.src_valid = '0;
      bus.src_addr  = '0;
      m_reset();
      @(posedge clock);
      @(posedge clock);
      #2;
      reset = 1'b0;
      chk("rst_pc",       bus.pc,                0);
      chk("rst_pc_prev",  bus.pc_prev,           0);
      chk("rst_redirect", 32'(bus.redirect),     0);
      chk("rst_pending",  32'(bus.pending),      0);

      // sequential fetch
      repeat (3) drive(0, 4'b0000, '0);
      settle();
      chk("seq_pc",      bus.pc,      32'h0C);
      chk("seq_pc_prev", bus.pc_prev, 32'h08);
      drive(0, 4'b0000, '0);

      // two requests: higher index wins
      drive(0, 4'b0011, pk(0, 0, 32'h100, 32'h200));
      settle();
      chk("prio_pc",  bus.pc,                    32'h100);
      chk("prio_src", 32'(bus.redirect_src),     1);
      drive(0, 4'b0000, '0);
      settle();
      chk("prio_next_pc",  bus.pc,               32'h104);
      chk("prio_next_red", 32'(bus.redirect),    0);

      // redirect latched under stall
      drive(0, 4'b0001, pk(0, 0, 0, 32'h20));
      drive(1, 4'b0001, pk(0, 0, 0, 32'h300));
      drive(1, 4'b0000, '0);
      drive(1, 4'b0000, '0);
      settle();
      chk("stall_hold_pc", bus.pc,               32'h20);
      chk("stall_pending", 32'(bus.pending),     1);
      drive(0, 4'b0000, '0);
      settle();
      chk("stall_rel_pc",  bus.pc,               32'h300);
      chk("stall_rel_pnd", 32'(bus.pending),     0);

      // pending replaced by higher index, lower index ignored
      drive(1, 4'b0010, pk(0, 0, 32'h400, 0));
      drive(1, 4'b1000, pk(32'h500, 0, 0, 0));
      drive(1, 4'b0001, pk(0, 0, 0, 32'h600));
      drive(0, 4'b0000, '0);
      settle();
      chk("pend_prio_pc",  bus.pc,               32'h500);
      chk("pend_prio_src", 32'(bus.redirect_src), 3);

      // misaligned target
      drive(0, 4'b0100, pk(0, 32'h1002, 0, 0));
      settle();
      chk("mis_pc",   bus.pc,                    32'h1000);
      chk("mis_flag", 32'(bus.misaligned),       1);
`ifdef PC_REDIRECT_COUNT_EN
      chk("mis_count", bus.redirect_count,       5);
`endif
      drive(0, 4'b0000, '0);

      // wrap-around of the sequential increment
      drive(0, 4'b0001, pk(0, 0, 0, 32'hFFFF_FFFC));
      drive(0, 4'b0000, '0);
      settle();
      chk("wrap_pc", bus.pc, 32'h0);

      // back-to-back redirects
      drive(0, 4'b0010, pk(0, 0, 32'h40, 0));
      drive(0, 4'b0100, pk(0, 32'h80, 0, 0));
      settle();
      chk("b2b_pc",  bus.pc,                     32'h80);
      chk("b2b_red", 32'(bus.redirect),          1);

      // same index as pending: current request wins
      drive(1, 4'b0010, pk(0, 0, 32'h900, 0));
      drive(0, 4'b0010, pk(0, 0, 32'hA00, 0));
      settle();
      chk("same_idx_pc", bus.pc, 32'hA00);

      // higher-index pending beats lower-index current request
      drive(1, 4'b1000, pk(32'hB00, 0, 0, 0));
      drive(0, 4'b0001, pk(0, 0, 0, 32'hC00));
      settle();
      chk("pend_beats_pc", bus.pc, 32'hB00);

      // asynchronous reset mid-stall with a redirect pending
      drive(1, 4'b0010, pk(0, 0, 32'h700, 0));
      settle();
      chk("arst_pre_pnd", 32'(bus.pending), 1);
      #1;
      reset = 1'b1;
      #1;
      chk("arst_pc",   bus.pc,               0);
      chk("arst_prev", bus.pc_prev,          0);
      chk("arst_pnd",  32'(bus.pending),     0);
      chk("arst_red",  32'(bus.redirect),    0);
      drive(1, 4'b0000, '0);
      @(posedge clock);
      #2;
      reset = 1'b0;
      drive(0, 4'b0000, '0);
      drive(0, 4'b0000, '0);
      settle();
      chk("arst_after_pc", bus.pc, 32'h8);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic        st;
         logic [3:0]  v;
         logic [127:0] a;
         st = ($urandom_range(0, 3) == 0);
         v  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
         a  = {$urandom, $urandom, $urandom, $urandom};
         drive(st, v, a);
      end

      drive(0, 4'b0000, '0);
      repeat (3) @(posedge clock);
      #3;
      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
